// File: rtl/uart_rx_fifo_if.sv
// Byte-strobe / FIFO read bundle for uart_rx_fifo.
// master: the surrounding logic that drives bytes and reads words; slave: the bridge itself.
interface uart_rx_fifo_if #(
    parameter int PACK  = 1,
    parameter int DEPTH = 16
);
    localparam int DW = 8 * PACK;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          flush;
    logic          rd;
    logic [DW-1:0] datout;
    logic          dato;
    logic          empy;
    logic          full;
    logic          afull;
    logic [LW-1:0] level;
    logic          ovf;

    modport master (
        output rx_data, rx_valid, flush, rd,
        input  datout, dato, empy, full, afull, level, ovf
    );

    modport slave (
        input  rx_data, rx_valid, flush, rd,
        output datout, dato, empy, full, afull, level, ovf
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART byte packer feeding a DEPTH-entry word FIFO with almost-full, level,
// sticky overflow, flush, and either first-word-fall-through or registered read.
module uart_rx_fifo #(
    parameter int PACK     = 1,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = 14,
    parameter int FWFT     = 1
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int DW = 8 * PACK;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [1:0]    LAST     = 2'(PACK - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_TH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q;
    logic [1:0]    cnt;
    logic [DW-1:0] acc, word;
    logic          ovf_q;
    logic          empy_w, full_w, word_done, pop, push_ok;

    assign empy_w    = (level_q == '0);
    assign full_w    = (level_q == LVL_FULL);
    assign word_done = bus.rx_valid && !bus.flush && (cnt == LAST);
    assign pop       = bus.rd && !empy_w && !bus.flush;
    // A full FIFO still accepts a word when the same edge frees a slot.
    assign push_ok   = word_done && (!full_w || pop);

    always_comb begin
        word = acc;
        for (int unsigned k = 0; k < PACK; k++) begin
            if (cnt == 2'(k)) word[8*k +: 8] = bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
            acc <= '0;
        end else if (bus.rx_valid) begin
            if (cnt == LAST) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + 2'd1;
                acc <= word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (word_done && !push_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= word;
    end

    assign bus.empy  = empy_w;
    assign bus.full  = full_w;
    assign bus.afull = (level_q >= LVL_AF);
    assign bus.level = level_q;
    assign bus.ovf   = ovf_q;

    generate
        if (FWFT != 0) begin : g_fwft
            // Gated so an empty FIFO presents zero rather than stale storage.
            assign bus.dato   = !empy_w;
            assign bus.datout = empy_w ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic          dato_q;
            logic [DW-1:0] dout_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dato_q <= 1'b0;
                    dout_q <= '0;
                end else begin
                    dato_q <= pop;
                    if (pop) dout_q <= mem[rd_ptr];
                end
            end
            assign bus.dato   = dato_q;
            assign bus.datout = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three instances cover PACK=1/FWFT=1,
// PACK=2/FWFT=1 and PACK=1/FWFT=0, all sharing one clock and reset.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.PACK(1), .DEPTH(16)) ia ();
    uart_rx_fifo_if #(.PACK(2), .DEPTH(16)) ib ();
    uart_rx_fifo_if #(.PACK(1), .DEPTH(16)) ic ();

    uart_rx_fifo #(.PACK(1), .DEPTH(16), .AFULL_TH(14), .FWFT(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    uart_rx_fifo #(.PACK(2), .DEPTH(16), .AFULL_TH(14), .FWFT(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    uart_rx_fifo #(.PACK(1), .DEPTH(16), .AFULL_TH(14), .FWFT(0)) dut_c (.clk(clk), .rst(rst), .bus(ic));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ia.rx_data = '0; ia.rx_valid = 1'b0; ia.flush = 1'b0; ia.rd = 1'b0;
        ib.rx_data = '0; ib.rx_valid = 1'b0; ib.flush = 1'b0; ib.rd = 1'b0;
        ic.rx_data = '0; ic.rx_valid = 1'b0; ic.flush = 1'b0; ic.rd = 1'b0;
    endtask

    initial begin
        idle();
        #2 rst = 1'b0;
        #1;
        chk("rst_level", 32'(ia.level), 32'd0);
        chk("rst_empy",  32'(ia.empy),  32'd1);
        chk("rst_full",  32'(ia.full),  32'd0);
        chk("rst_afull", 32'(ia.afull), 32'd0);
        chk("rst_dato",  32'(ia.dato),  32'd0);
        chk("rst_datout",32'(ia.datout),32'd0);
        chk("rst_ovf",   32'(ia.ovf),   32'd0);
        chk("rst_c_dout",32'(ic.datout),32'd0);
        tick(); tick();
        rst = 1'b1;

        // PACK=1 FWFT: two bytes, then read them back
        ia.rx_valid = 1'b1; ia.rx_data = 8'hA5; tick();
        chk("a_lvl1",   32'(ia.level),  32'd1);
        chk("a_dato1",  32'(ia.dato),   32'd1);
        chk("a_head1",  32'(ia.datout), 32'hA5);
        ia.rx_data = 8'h3C; tick();
        chk("a_lvl2",   32'(ia.level),  32'd2);
        chk("a_head2",  32'(ia.datout), 32'hA5);
        ia.rx_valid = 1'b0; ia.rd = 1'b1; tick();
        chk("a_pop1",   32'(ia.datout), 32'h3C);
        chk("a_lvlp1",  32'(ia.level),  32'd1);
        tick();
        chk("a_lvlp2",  32'(ia.level),  32'd0);
        chk("a_empy",   32'(ia.empy),   32'd1);
        chk("a_dato0",  32'(ia.dato),   32'd0);
        tick();
        chk("a_rd_empty_lvl", 32'(ia.level), 32'd0);
        chk("a_rd_empty_emp", 32'(ia.empy),  32'd1);
        ia.rd = 1'b0;

        // Overfill with 17 bytes
        for (int i = 0; i < 17; i++) begin
            ia.rx_valid = 1'b1; ia.rx_data = 8'(i + 1); tick();
            if (i == 12) chk("a_afull13", 32'(ia.afull), 32'd0);
            if (i == 13) begin
                chk("a_afull14", 32'(ia.afull), 32'd1);
                chk("a_full14",  32'(ia.full),  32'd0);
            end
            if (i == 15) begin
                chk("a_full16", 32'(ia.full), 32'd1);
                chk("a_ovf16",  32'(ia.ovf),  32'd0);
            end
        end
        chk("a_ovf17",  32'(ia.ovf),    32'd1);
        chk("a_lvl17",  32'(ia.level),  32'd16);
        chk("a_head17", 32'(ia.datout), 32'h01);

        // Flush beats a simultaneous strobe and read
        ia.rx_data = 8'hEE; ia.rd = 1'b1; ia.flush = 1'b1; tick();
        idle();
        chk("a_fl_lvl",  32'(ia.level), 32'd0);
        chk("a_fl_ovf",  32'(ia.ovf),   32'd0);
        chk("a_fl_empy", 32'(ia.empy),  32'd1);
        chk("a_fl_dato", 32'(ia.dato),  32'd0);

        for (int i = 0; i < 16; i++) begin
            ia.rx_valid = 1'b1; ia.rx_data = 8'(8'h40 + i); tick();
        end
        chk("a_refull",  32'(ia.full),   32'd1);
        chk("a_rehead",  32'(ia.datout), 32'h40);
        // Push while full with a same-cycle pop
        ia.rx_data = 8'h99; ia.rd = 1'b1; tick();
        chk("a_fp_lvl",  32'(ia.level),  32'd16);
        chk("a_fp_ovf",  32'(ia.ovf),    32'd0);
        chk("a_fp_head", 32'(ia.datout), 32'h41);
        ia.rx_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            chk("a_drain", 32'(ia.datout), (j < 15) ? 32'(8'h41 + j) : 32'h99);
            tick();
        end
        chk("a_drained", 32'(ia.empy), 32'd1);
        idle();

        // PACK=2 packing and flush of a partial word
        ib.rx_valid = 1'b1; ib.rx_data = 8'h11; tick();
        chk("b_half",   32'(ib.level),  32'd0);
        ib.rx_data = 8'h22; tick();
        chk("b_lvl1",   32'(ib.level),  32'd1);
        chk("b_word",   32'(ib.datout), 32'h2211);
        ib.rx_data = 8'h33; tick();
        chk("b_single", 32'(ib.level),  32'd1);
        ib.rx_valid = 1'b0; ib.flush = 1'b1; tick();
        ib.flush = 1'b0;
        chk("b_fl_lvl", 32'(ib.level),  32'd0);
        chk("b_fl_emp", 32'(ib.empy),   32'd1);
        chk("b_fl_ovf", 32'(ib.ovf),    32'd0);
        ib.rx_valid = 1'b1; ib.rx_data = 8'h01; tick();
        ib.rx_valid = 1'b0; ib.flush = 1'b1; tick();
        ib.flush = 1'b0;
        chk("b_fl2_lvl", 32'(ib.level), 32'd0);
        ib.rx_valid = 1'b1; ib.rx_data = 8'h02; tick();
        ib.rx_data = 8'h03; tick();
        ib.rx_valid = 1'b0;
        chk("b_w2_lvl", 32'(ib.level),  32'd1);
        chk("b_w2",     32'(ib.datout), 32'h0302);

        // FWFT=0 registered read
        ic.rx_valid = 1'b1; ic.rx_data = 8'h5A; tick();
        ic.rx_valid = 1'b0;
        chk("c_lvl1",   32'(ic.level),  32'd1);
        chk("c_dato0",  32'(ic.dato),   32'd0);
        chk("c_dout0",  32'(ic.datout), 32'd0);
        ic.rd = 1'b1; tick();
        ic.rd = 1'b0;
        chk("c_dato1",  32'(ic.dato),   32'd1);
        chk("c_dout1",  32'(ic.datout), 32'h5A);
        chk("c_empy",   32'(ic.empy),   32'd1);
        tick();
        chk("c_dato_off", 32'(ic.dato),   32'd0);
        chk("c_hold",     32'(ic.datout), 32'h5A);
        ic.rd = 1'b1; tick();
        ic.rd = 1'b0;
        chk("c_rde_dato", 32'(ic.dato),   32'd0);
        chk("c_rde_lvl",  32'(ic.level),  32'd0);
        chk("c_rde_hold", 32'(ic.datout), 32'h5A);

        // Asynchronous reset mid-stream
        ia.rx_valid = 1'b1; ia.rx_data = 8'h77;
        ib.rx_valid = 1'b1; ib.rx_data = 8'h44;
        tick();
        idle();
        chk("ar_pre_lvl", 32'(ia.level), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_a_lvl",  32'(ia.level),  32'd0);
        chk("ar_a_empy", 32'(ia.empy),   32'd1);
        chk("ar_a_dato", 32'(ia.dato),   32'd0);
        chk("ar_a_dout", 32'(ia.datout), 32'd0);
        chk("ar_b_lvl",  32'(ib.level),  32'd0);
        chk("ar_c_dout", 32'(ic.datout), 32'd0);
        tick(); tick();
        rst = 1'b1;
        ib.rx_valid = 1'b1; ib.rx_data = 8'h55; tick();
        ib.rx_data = 8'h66; tick();
        ib.rx_valid = 1'b0;
        chk("ar_b_repack", 32'(ib.datout), 32'h6655);
        chk("ar_b_relvl",  32'(ib.level),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
